// File: rtl/reg_bank.sv
// Parametrised register file with two combinational read ports, a status-read
// address, optional write-to-read bypass and a sequenced bulk-clear engine.
module reg_bank #(
  parameter int DW        = 8,
  parameter int PW        = 3,
  parameter int STAT_ADDR = 6,
  parameter int BYPASS    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dat_in,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic          par,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  input  logic          clr_req,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          busy,
  output logic          clr_done,
  output logic          wr_drop
);

  localparam int unsigned DEPTH = 1 << PW;
  localparam logic [PW-1:0] LAST_IDX = '1;
  // A status address outside the storage range simply never matches.
  localparam logic STAT_IN_RANGE = (STAT_ADDR >= 0) && (STAT_ADDR < (1 << PW));
  localparam logic [PW-1:0] STAT_A = PW'(STAT_ADDR);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] idx;
  logic [DW-1:0] mem [DEPTH];

  logic wr_stat;
  logic rdA_stat;
  logic rdB_stat;
  logic wr_live;
  logic byp_a;
  logic byp_b;
  logic last_step;

  assign wr_stat   = STAT_IN_RANGE && (wr_addr == STAT_A);
  assign rdA_stat  = STAT_IN_RANGE && (rd_addrA == STAT_A);
  assign rdB_stat  = STAT_IN_RANGE && (rd_addrB == STAT_A);
  assign wr_live   = wr_en && (state == IDLE) && !wr_stat;
  assign last_step = (state == CLEAR) && (idx == LAST_IDX);

  assign byp_a = (BYPASS != 0) && wr_live && (wr_addr == rd_addrA);
  assign byp_b = (BYPASS != 0) && wr_live && (wr_addr == rd_addrB);

  always_comb begin
    datA_out = mem[rd_addrA];
    if (rdA_stat)   datA_out = DW'(par);
    else if (byp_a) datA_out = dat_in;
  end

  always_comb begin
    datB_out = mem[rd_addrB];
    if (rdB_stat)   datB_out = DW'(par);
    else if (byp_b) datB_out = dat_in;
  end

  // Storage: normal writes only in IDLE; the sweep zeroes one entry per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[idx] <= '0;
    end else if (wr_live) begin
      mem[wr_addr] <= dat_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            idx   <= '0;
          end
        end
        CLEAR: begin
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      clr_done <= last_step;
      wr_drop  <= wr_en && ((state == CLEAR) || wr_stat);
    end
  end

  assign busy = (state == CLEAR);

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: directed vector table, hand sequences and randomized
// traffic against a cycle-level behavioural model.
module tb_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dat_in;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic       par;
  logic [2:0] rd_addrA;
  logic [2:0] rd_addrB;
  logic       clr_req;
  logic [7:0] datA_out, datB_out, datA_nb, datB_nb;
  logic       busy, clr_done, wr_drop, busy_nb, done_nb, drop_nb;

  always #5 clk = ~clk;

  reg_bank #(.DW(8), .PW(3), .STAT_ADDR(6), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .dat_in(dat_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .par(par), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .clr_req(clr_req),
    .datA_out(datA_out), .datB_out(datB_out), .busy(busy), .clr_done(clr_done),
    .wr_drop(wr_drop)
  );

  reg_bank #(.DW(8), .PW(3), .STAT_ADDR(6), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .dat_in(dat_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .par(par), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .clr_req(clr_req),
    .datA_out(datA_nb), .datB_out(datB_nb), .busy(busy_nb), .clr_done(done_nb),
    .wr_drop(drop_nb)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Behavioural model: sweep_t < 0 means no clear running, otherwise it is the
  // number of entries already zeroed by the current sweep.
  logic [7:0] m_mem [8];
  int         sweep_t;
  logic       m_done, m_drop;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    sweep_t = -1;
    m_done  = 1'b0;
    m_drop  = 1'b0;
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] a, input bit byp);
    if (a == 3'd6) return {7'b0, par};
    if (byp && sweep_t < 0 && wr_en && wr_addr == a) return dat_in;
    return m_mem[a];
  endfunction

  function automatic void model_step();
    logic nd, ndr;
    nd  = 1'b0;
    ndr = 1'b0;
    if (sweep_t >= 0) begin
      m_mem[sweep_t] = 8'h00;
      ndr = wr_en;
      if (sweep_t == 7) begin
        sweep_t = -1;
        nd = 1'b1;
      end else begin
        sweep_t++;
      end
    end else begin
      if (wr_en) begin
        if (wr_addr == 3'd6) ndr = 1'b1;
        else m_mem[wr_addr] = dat_in;
      end
      if (clr_req) sweep_t = 0;
    end
    m_done = nd;
    m_drop = ndr;
  endfunction

  task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] d,
                       input logic [2:0] ra, input logic [2:0] rb, input logic p,
                       input logic clr);
    wr_en = we; wr_addr = wa; dat_in = d;
    rd_addrA = ra; rd_addrB = rb; par = p; clr_req = clr;
  endtask

  task automatic model_cycle(input string tag);
    @(negedge clk);
    chk({tag, "_A"},    datA_out, m_read(rd_addrA, 1'b1));
    chk({tag, "_B"},    datB_out, m_read(rd_addrB, 1'b1));
    chk({tag, "_Anb"},  datA_nb,  m_read(rd_addrA, 1'b0));
    chk({tag, "_busy"}, busy,     sweep_t >= 0);
    chk({tag, "_done"}, clr_done, m_done);
    chk({tag, "_drop"}, wr_drop,  m_drop);
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] d;
    logic [2:0] ra, rb;
    logic       p, clr;
    logic [7:0] ea, eb, ea_nb;
    logic       eby, edn, edr;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic we, input logic [2:0] wa, input logic [7:0] d,
                              input logic [2:0] ra, input logic [2:0] rb, input logic p,
                              input logic clr, input logic [7:0] ea, input logic [7:0] eb,
                              input logic [7:0] ea_nb, input logic eby, input logic edn,
                              input logic edr);
    vec_t v;
    v.we = we; v.wa = wa; v.d = d; v.ra = ra; v.rb = rb; v.p = p; v.clr = clr;
    v.ea = ea; v.eb = eb; v.ea_nb = ea_nb; v.eby = eby; v.edn = edn; v.edr = edr;
    vq.push_back(v);
  endfunction

  function automatic logic [7:0] fill_val(input int a);
    return (a == 6) ? 8'h01 : 8'(8'h11 * (a + 1));
  endfunction

  initial begin
    int ra, rb;
    logic [7:0] ea, eb;

    // Reset state: all zero except the status address (par = 1).
    for (int i = 0; i < 8; i++)
      add(0, 0, 0, 3'(i), 3'(7 - i), 1, 0, (i == 6) ? 8'h01 : 8'h00,
          (7 - i == 6) ? 8'h01 : 8'h00, (i == 6) ? 8'h01 : 8'h00, 0, 0, 0);
    // Bypass vs. no bypass on a same-cycle write/read.
    add(1, 3, 8'hA5, 3, 0, 1, 0, 8'hA5, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 8'h00, 3, 3, 1, 0, 8'hA5, 8'hA5, 8'hA5, 0, 0, 0);
    // Status-address write is dropped.
    add(1, 6, 8'h3C, 6, 6, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 8'h00, 6, 3, 1, 0, 8'h01, 8'hA5, 8'h01, 0, 0, 1);
    add(0, 0, 8'h00, 6, 6, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    // Fill 0x11..0x88 (the write to 6 is dropped).
    for (int k = 0; k < 8; k++)
      add(1, 3'(k), 8'(8'h11 * (k + 1)), 3'(k), 0, 1, 0, fill_val(k), 8'h11,
          (k == 6) ? 8'h01 : ((k == 3) ? 8'hA5 : 8'h00), 0, 0, k == 7);
    add(0, 0, 8'h00, 7, 4, 1, 1, 8'h88, 8'h55, 8'h88, 0, 0, 0);
    // Sweep: busy for 8 cycles, a write + re-request at step 2 is dropped.
    for (int s = 0; s < 8; s++) begin
      ra = (s == 2) ? 7 : s;
      rb = (s == 0) ? 7 : ((s == 2) ? 2 : s - 1);
      ea = fill_val(ra);
      eb = (s == 0 || s == 2) ? fill_val(rb) : ((rb == 6) ? 8'h01 : 8'h00);
      add(s == 2, 7, 8'hFF, 3'(ra), 3'(rb), 1, s == 2, ea, eb, ea, 1, 0, s == 3);
    end
    // clr_req in the clr_done cycle starts a new sweep.
    add(0, 0, 8'h00, 7, 0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      add(0, 0, 8'h00, 3'(i), 3'((i + 4) % 8), 1, 0, (i == 6) ? 8'h01 : 8'h00,
          ((i + 4) % 8 == 6) ? 8'h01 : 8'h00, (i == 6) ? 8'h01 : 8'h00, 1, 0, 0);
    add(0, 0, 8'h00, 3, 5, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 7, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vq[r]) begin
      drive(vq[r].we, vq[r].wa, vq[r].d, vq[r].ra, vq[r].rb, vq[r].p, vq[r].clr);
      @(negedge clk);
      chk($sformatf("tbl%0d_A", r),    datA_out, vq[r].ea);
      chk($sformatf("tbl%0d_B", r),    datB_out, vq[r].eb);
      chk($sformatf("tbl%0d_Anb", r),  datA_nb,  vq[r].ea_nb);
      chk($sformatf("tbl%0d_busy", r), busy,     vq[r].eby);
      chk($sformatf("tbl%0d_done", r), clr_done, vq[r].edn);
      chk($sformatf("tbl%0d_drop", r), wr_drop,  vq[r].edr);
      model_step();
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a sweep.
    for (int k = 0; k < 8; k++) begin
      drive(1, 3'(k), 8'(8'h90 + k), 3'(k), 3'(7 - k), 1, 0);
      model_cycle("fill2");
    end
    drive(0, 0, 0, 5, 7, 1, 1);
    model_cycle("clr2");
    drive(0, 0, 0, 5, 7, 1, 0);
    repeat (3) model_cycle("sweep2");
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", clr_done, 1'b0);
    for (int a = 0; a < 8; a++) begin
      drive(0, 0, 0, 3'(a), 3'(a), 0, 0);
      #1;
      chk($sformatf("rst_A%0d", a), datA_out, 8'h00);
      chk($sformatf("rst_B%0d", a), datB_out, 8'h00);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 2, 5, 1, 0);
    repeat (10) model_cycle("postrst");
    drive(1, 2, 8'h42, 0, 1, 1, 0);
    model_cycle("wr42");
    drive(0, 0, 0, 2, 2, 1, 0);
    @(negedge clk);
    chk("rd42_A", datA_out, 8'h42);
    chk("rd42_Anb", datA_nb, 8'h42);
    model_step();
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 2) == 1, 3'($urandom_range(0, 7)), 8'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom % 2) == 1, ($urandom % 16) == 0);
      model_cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
